// File: rtl/mux_scan_sequencer.sv
// Byte-to-serial scan driver for an 8:1 selector: latches a byte, steps S through all
// positions, samples F. Optional self-check comparator enabled by macro MUX_SCAN_CHECK_EN.
module mux_scan_sequencer #(
    parameter int HOLD_CYCLES = 1,
    parameter bit MSB_FIRST   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic [7:0] mux_I,
    output logic [2:0] mux_S,
    input  logic       mux_F,
    output logic       ser_bit,
    output logic       ser_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       busy,
    output logic       mismatch
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [2:0] S_START   = MSB_FIRST ? 3'd7 : 3'd0;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] hold_cnt;
    logic [2:0] step;
    logic       accept;
    logic       sample;
    logic       last_sample;

    function automatic logic [2:0] next_sel(input logic [2:0] s);
        return MSB_FIRST ? (s - 3'd1) : (s + 3'd1);
    endfunction

    assign in_ready = (state == IDLE);
    assign busy     = (state == SCAN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        accept      = in_valid && (state == IDLE);
        sample      = (state == SCAN) && (hold_cnt == HOLD_LAST);
        last_sample = sample && (step == 3'd7);
        state_nxt   = state;
        case (state)
            IDLE:    if (accept) state_nxt = SCAN;
            SCAN:    if (last_sample) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Select stays on one position for HOLD_CYCLES edges; F is captured on the last of them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mux_I     <= 8'd0;
            mux_S     <= 3'd0;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            out_data  <= 8'd0;
            out_valid <= 1'b0;
            hold_cnt  <= 4'd0;
            step      <= 3'd0;
        end else begin
            ser_valid <= 1'b0;
            out_valid <= 1'b0;
            if (accept) begin
                mux_I    <= in_data;
                mux_S    <= S_START;
                hold_cnt <= 4'd0;
                step     <= 3'd0;
                out_data <= 8'd0;
            end else if (state == SCAN) begin
                if (sample) begin
                    ser_bit         <= mux_F;
                    ser_valid       <= 1'b1;
                    out_data[mux_S] <= mux_F;
                    hold_cnt        <= 4'd0;
                    if (step == 3'd7) begin
                        out_valid <= 1'b1;
                    end else begin
                        step  <= step + 3'd1;
                        mux_S <= next_sel(mux_S);
                    end
                end else begin
                    hold_cnt <= hold_cnt + 4'd1;
                end
            end
        end
    end

`ifdef MUX_SCAN_CHECK_EN
    logic [7:0] final_byte;

    // The final bit is not yet in out_data at the last sample edge, so merge it here.
    always_comb begin
        final_byte        = out_data;
        final_byte[mux_S] = mux_F;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mismatch <= 1'b0;
        end else if (accept) begin
            mismatch <= 1'b0;
        end else if (last_sample) begin
            mismatch <= (final_byte != mux_I);
        end
    end
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: instance A (H=1, LSB first) and
// instance B (H=3, MSB first), each driven by a behavioural 8:1 selector.
module tb_mux_scan_sequencer;

`ifdef MUX_SCAN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'd0;

    logic       in_valid_a = 1'b0, in_ready_a, ser_bit_a, ser_valid_a, out_valid_a, busy_a, mismatch_a, mux_F_a;
    logic [7:0] mux_I_a, out_data_a;
    logic [2:0] mux_S_a;
    logic       force_zero_a = 1'b0;

    logic       in_valid_b = 1'b0, in_ready_b, ser_bit_b, ser_valid_b, out_valid_b, busy_b, mismatch_b, mux_F_b;
    logic [7:0] mux_I_b, out_data_b;
    logic [2:0] mux_S_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign mux_F_a = force_zero_a ? 1'b0 : mux_I_a[mux_S_a];
    assign mux_F_b = mux_I_b[mux_S_b];

    mux_scan_sequencer #(.HOLD_CYCLES(1), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data),
        .mux_I(mux_I_a), .mux_S(mux_S_a), .mux_F(mux_F_a), .ser_bit(ser_bit_a), .ser_valid(ser_valid_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .busy(busy_a), .mismatch(mismatch_a)
    );

    mux_scan_sequencer #(.HOLD_CYCLES(3), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data),
        .mux_I(mux_I_b), .mux_S(mux_S_b), .mux_F(mux_F_b), .ser_bit(ser_bit_b), .ser_valid(ser_valid_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .busy(busy_b), .mismatch(mismatch_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] got_a, got_b;
        logic [31:0] exp_v;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        exp_v = {8'd0, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        got_a = {mux_I_a, out_data_a, mux_S_a, ser_bit_a, ser_valid_a, out_valid_a, in_ready_a, busy_a, mismatch_a, 7'd0};
        got_b = {mux_I_b, out_data_b, mux_S_b, ser_bit_b, ser_valid_b, out_valid_b, in_ready_b, busy_b, mismatch_b, 7'd0};
        tests++;
        if (got_a !== exp_v) begin
            fails++;
            $display("FAIL reset_a: got %h expected %h", got_a, exp_v);
        end
        tests++;
        if (got_b !== exp_v) begin
            fails++;
            $display("FAIL reset_b: got %h expected %h", got_b, exp_v);
        end
    endtask

    task automatic test_lsb_h1();
        logic [7:0] pat = 8'hA5;
        int idx;
        in_data = pat;
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        tests++;
        if ({busy_a, in_ready_a, mux_S_a, mux_I_a} !== {1'b1, 1'b0, 3'd0, pat}) begin
            fails++;
            $display("FAIL lsb_accept: got busy=%b rdy=%b S=%0d I=%h", busy_a, in_ready_a, mux_S_a, mux_I_a);
        end
        in_data = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            tick();
            idx = (k < 7) ? k : 7;
            tests++;
            if ({ser_valid_a, ser_bit_a, out_valid_a, mux_S_a, mux_I_a} !==
                {1'b1, pat[k-1], (k == 8), 3'(idx), pat}) begin
                fails++;
                $display("FAIL lsb_edge%0d: got sv=%b bit=%b ov=%b S=%0d I=%h expected bit=%b S=%0d",
                         k, ser_valid_a, ser_bit_a, out_valid_a, mux_S_a, mux_I_a, pat[k-1], idx);
            end
        end
        tests++;
        if ({out_data_a, in_ready_a, busy_a} !== {pat, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL lsb_done: got data=%h rdy=%b busy=%b expected %h", out_data_a, in_ready_a, busy_a, pat);
        end
        tick();
        tests++;
        if ({ser_valid_a, out_valid_a} !== 2'b00) begin
            fails++;
            $display("FAIL lsb_strobe_len: got sv=%b ov=%b expected 0 0", ser_valid_a, out_valid_a);
        end
    endtask

    task automatic test_msb_h3();
        logic [7:0] pat = 8'h3C;
        int idx;
        logic exp_sv;
        logic [2:0] bit_sel;
        in_data = pat;
        in_valid_b = 1'b1;
        tick();
        in_valid_b = 1'b0;
        tests++;
        if ({busy_b, mux_S_b, mux_I_b} !== {1'b1, 3'd7, pat}) begin
            fails++;
            $display("FAIL msb_accept: got busy=%b S=%0d I=%h", busy_b, mux_S_b, mux_I_b);
        end
        for (int k = 1; k <= 24; k++) begin
            tick();
            exp_sv = (k % 3 == 0);
            idx = (k / 3 < 7) ? k / 3 : 7;
            bit_sel = 3'(8 - k / 3);
            tests++;
            if ({ser_valid_b, out_valid_b, mux_S_b, mux_I_b} !== {exp_sv, (k == 24), 3'(7 - idx), pat}) begin
                fails++;
                $display("FAIL msb_edge%0d: got sv=%b ov=%b S=%0d I=%h expected sv=%b S=%0d",
                         k, ser_valid_b, out_valid_b, mux_S_b, mux_I_b, exp_sv, 7 - idx);
            end
            if (exp_sv) begin
                tests++;
                if (ser_bit_b !== pat[bit_sel]) begin
                    fails++;
                    $display("FAIL msb_bit_edge%0d: got %b expected %b", k, ser_bit_b, pat[bit_sel]);
                end
            end
        end
        tests++;
        if (out_data_b !== pat) begin
            fails++;
            $display("FAIL msb_data: got %h expected %h", out_data_b, pat);
        end
    endtask

    task automatic test_back_to_back();
        int ov_seen = 0;
        in_data = 8'h01;
        in_valid_a = 1'b1;
        tick();
        in_data = 8'hFF;
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) in_data = 8'h77;
            if (k == 6) in_data = 8'hFF;
            tick();
            if (out_valid_a) ov_seen++;
            tests++;
            if ({mux_I_a, busy_a} !== {8'h01, (k != 8)}) begin
                fails++;
                $display("FAIL b2b_first_edge%0d: got I=%h busy=%b expected 01", k, mux_I_a, busy_a);
            end
        end
        tests++;
        if ({out_valid_a, out_data_a, in_ready_a} !== {1'b1, 8'h01, 1'b1}) begin
            fails++;
            $display("FAIL b2b_first_done: got ov=%b data=%h rdy=%b expected 1 01 1", out_valid_a, out_data_a, in_ready_a);
        end
        tick();
        in_valid_a = 1'b0;
        tests++;
        if ({busy_a, mux_I_a, out_valid_a} !== {1'b1, 8'hFF, 1'b0}) begin
            fails++;
            $display("FAIL b2b_second_accept: got busy=%b I=%h ov=%b expected 1 ff 0", busy_a, mux_I_a, out_valid_a);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (out_valid_a) ov_seen++;
        end
        tests++;
        if ({out_valid_a, out_data_a, ov_seen[3:0]} !== {1'b1, 8'hFF, 4'd2}) begin
            fails++;
            $display("FAIL b2b_second_done: got ov=%b data=%h strobes=%0d expected 1 ff 2", out_valid_a, out_data_a, ov_seen);
        end
    endtask

    task automatic test_reset_mid_scan();
        int bad = 0;
        in_data = 8'h55;
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests++;
        if ({ser_valid_a, out_valid_a, busy_a, in_ready_a, out_data_a, mux_I_a} !== {4'b0001, 8'h00, 8'h00}) begin
            fails++;
            $display("FAIL abort_reset: got sv=%b ov=%b busy=%b rdy=%b data=%h I=%h", ser_valid_a, out_valid_a,
                     busy_a, in_ready_a, out_data_a, mux_I_a);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (ser_valid_a || out_valid_a || busy_a) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL abort_quiet: got %0d active cycles expected 0", bad);
        end
        in_data = 8'h0F;
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        tests++;
        if ({out_valid_a, out_data_a} !== {1'b1, 8'h0F}) begin
            fails++;
            $display("FAIL abort_next: got ov=%b data=%h expected 1 0f", out_valid_a, out_data_a);
        end
    endtask

    task automatic test_self_check();
        force_zero_a = 1'b1;
        in_data = 8'h80;
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        tests++;
        if ({out_valid_a, out_data_a, mismatch_a} !== {1'b1, 8'h00, CHECK_EN}) begin
            fails++;
            $display("FAIL check_flag: got ov=%b data=%h mm=%b expected 1 00 %b", out_valid_a, out_data_a, mismatch_a, CHECK_EN);
        end
        repeat (3) tick();
        tests++;
        if (mismatch_a !== CHECK_EN) begin
            fails++;
            $display("FAIL check_sticky: got %b expected %b", mismatch_a, CHECK_EN);
        end
        in_data = 8'h00;
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        tests++;
        if ({busy_a, mismatch_a} !== 2'b10) begin
            fails++;
            $display("FAIL check_clear: got busy=%b mm=%b expected 1 0", busy_a, mismatch_a);
        end
        for (int k = 1; k <= 8; k++) tick();
        tests++;
        if ({out_valid_a, out_data_a, mismatch_a} !== {1'b1, 8'h00, 1'b0}) begin
            fails++;
            $display("FAIL check_match: got ov=%b data=%h mm=%b expected 1 00 0", out_valid_a, out_data_a, mismatch_a);
        end
        force_zero_a = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lsb_h1();
        test_msb_h3();
        test_back_to_back();
        test_reset_mid_scan();
        test_self_check();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
